// File: rtl/alu_share_arb.sv
// Two-port round-robin arbiter in front of a shared combinational alu32.
// Each port has a one-entry response register; C/V flags and the CPSR write are generated here.
module alu_share_arb #(
    parameter int DW = 32,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [CW-1:0] req0_code,
    input  logic [DW-1:0] req0_rn,
    input  logic [DW-1:0] req0_shift,
    input  logic          req0_s,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [CW-1:0] req1_code,
    input  logic [DW-1:0] req1_rn,
    input  logic [DW-1:0] req1_shift,
    input  logic          req1_s,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_out,
    output logic [3:0]    rsp0_flags,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_out,
    output logic [3:0]    rsp1_flags,
    output logic [CW-1:0] alu_code,
    output logic [DW-1:0] alu_rn,
    output logic [DW-1:0] alu_shift,
    input  logic [DW-1:0] alu_out,
    input  logic [3:0]    alu_flags,
    input  logic [3:0]    cpsr_in,
    output logic          cpsr_we,
    output logic [3:0]    cpsr_wdata
);
    localparam logic [CW-1:0] OP_SUB = CW'(2);
    localparam logic [CW-1:0] OP_RSB = CW'(3);
    localparam logic [CW-1:0] OP_ADD = CW'(4);
    localparam logic [CW-1:0] OP_CMP = CW'(10);
    localparam logic [CW-1:0] OP_CMN = CW'(11);

    logic [1:0]    req_valid, req_s, rsp_ready_w, elig, grant;
    logic [CW-1:0] req_code  [2];
    logic [DW-1:0] req_rn    [2];
    logic [DW-1:0] req_shift [2];

    logic [1:0]    rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_out_q   [2];
    logic [DW-1:0] rsp_out_d   [2];
    logic [3:0]    rsp_flags_q [2];
    logic [3:0]    rsp_flags_d [2];
    logic          cpsr_we_q, cpsr_we_d;
    logic [3:0]    cpsr_wdata_q, cpsr_wdata_d;
    logic          rr_ptr_q, rr_ptr_d;

    logic [DW-1:0] add_res;
    logic          c_new, v_new;
    logic [3:0]    flags_new;
    logic [1:0]    unused_alu_flags;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_s       = {req1_s, req0_s};
    assign rsp_ready_w = {rsp1_ready, rsp0_ready};
    assign req_code    = '{req0_code, req1_code};
    assign req_rn      = '{req0_rn, req1_rn};
    assign req_shift   = '{req0_shift, req1_shift};
    assign unused_alu_flags = {alu_flags[3], alu_flags[1]};

    // A full slot can still take a new result if it is being drained this very cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
        assign elig[gi] = req_valid[gi] & (~rsp_valid_q[gi] | rsp_ready_w[gi]);
    end

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (elig[0] && (!elig[1] || !rr_ptr_q)) grant[0] = 1'b1;
            else if (elig[1])                       grant[1] = 1'b1;
        end
    end

    always_comb begin
        alu_code  = '0;
        alu_rn    = '0;
        alu_shift = '0;
        if (grant[0]) begin
            alu_code = req_code[0]; alu_rn = req_rn[0]; alu_shift = req_shift[0];
        end else if (grant[1]) begin
            alu_code = req_code[1]; alu_rn = req_rn[1]; alu_shift = req_shift[1];
        end
    end

    // Carry of an add shows up as a wrapped sum smaller than either operand.
    assign add_res = alu_rn + alu_shift;

    always_comb begin
        c_new = cpsr_in[1];
        v_new = cpsr_in[3];
        case (alu_code)
            OP_ADD, OP_CMN: begin
                c_new = add_res < alu_rn;
                v_new = (alu_rn[DW-1] == alu_shift[DW-1]) && (alu_out[DW-1] != alu_rn[DW-1]);
            end
            OP_SUB, OP_CMP: begin
                c_new = alu_rn >= alu_shift;
                v_new = (alu_rn[DW-1] != alu_shift[DW-1]) && (alu_out[DW-1] != alu_rn[DW-1]);
            end
            OP_RSB: begin
                c_new = alu_shift >= alu_rn;
                v_new = (alu_shift[DW-1] != alu_rn[DW-1]) && (alu_out[DW-1] != alu_shift[DW-1]);
            end
            default: ;
        endcase
    end

    assign flags_new = {v_new, alu_flags[2], c_new, alu_flags[0]};

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        cpsr_we_d    = 1'b0;
        cpsr_wdata_d = cpsr_wdata_q;
        for (int i = 0; i < 2; i++) begin
            rsp_valid_d[i] = rsp_valid_q[i] & ~rsp_ready_w[i];
            rsp_out_d[i]   = rsp_out_q[i];
            rsp_flags_d[i] = rsp_flags_q[i];
            if (grant[i]) begin
                rsp_valid_d[i] = 1'b1;
                rsp_out_d[i]   = alu_out;
                rsp_flags_d[i] = flags_new;
                rr_ptr_d       = (i == 0);
                cpsr_we_d      = req_s[i];
                if (req_s[i]) cpsr_wdata_d = flags_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q  <= '0;
            cpsr_we_q    <= 1'b0;
            cpsr_wdata_q <= '0;
            rr_ptr_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                rsp_out_q[i]   <= '0;
                rsp_flags_q[i] <= '0;
            end
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            cpsr_we_q    <= cpsr_we_d;
            cpsr_wdata_q <= cpsr_wdata_d;
            rr_ptr_q     <= rr_ptr_d;
            for (int i = 0; i < 2; i++) begin
                rsp_out_q[i]   <= rsp_out_d[i];
                rsp_flags_q[i] <= rsp_flags_d[i];
            end
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_out   = rsp_out_q[0];
    assign rsp1_out   = rsp_out_q[1];
    assign rsp0_flags = rsp_flags_q[0];
    assign rsp1_flags = rsp_flags_q[1];
    assign cpsr_we    = cpsr_we_q;
    assign cpsr_wdata = cpsr_wdata_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: stand-in alu32, directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a slot/queue-level reference model.
module tb_alu_share_arb;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [3:0]  req_code  [2];
    logic [31:0] req_rn    [2];
    logic [31:0] req_shift [2];
    logic        req_s     [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_out   [2];
    logic [3:0]  rsp_flags [2];
    logic [3:0]  alu_code;
    logic [31:0] alu_rn, alu_shift, alu_out;
    logic [3:0]  alu_flags, cpsr_in, cpsr_wdata;
    logic        cpsr_we;

    int n_err = 0, n_checks = 0;

    // reference model state
    bit          m_full  [2];
    logic [31:0] m_out   [2];
    logic [3:0]  m_flags [2];
    bit          m_we;
    logic [3:0]  m_wdata;
    int          m_pref;
    int          last_g;
    logic        dut_r0, dut_r1;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    alu_share_arb dut (
        .clk(clk), .reset(reset),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_code(req_code[0]),
        .req0_rn(req_rn[0]), .req0_shift(req_shift[0]), .req0_s(req_s[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_code(req_code[1]),
        .req1_rn(req_rn[1]), .req1_shift(req_shift[1]), .req1_s(req_s[1]),
        .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_out(rsp_out[0]),
        .rsp0_flags(rsp_flags[0]),
        .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_out(rsp_out[1]),
        .rsp1_flags(rsp_flags[1]),
        .alu_code(alu_code), .alu_rn(alu_rn), .alu_shift(alu_shift),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .cpsr_in(cpsr_in), .cpsr_we(cpsr_we), .cpsr_wdata(cpsr_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(logic [3:0] code, logic [31:0] rn, logic [31:0] sh);
        case (code)
            4'd0:  return rn & sh;
            4'd1:  return rn ^ sh;
            4'd2:  return rn - sh;
            4'd3:  return sh - rn;
            4'd4:  return rn + sh;
            4'd5:  return rn + sh;
            4'd8:  return rn & sh;
            4'd9:  return rn ^ sh;
            4'd10: return rn - sh;
            4'd11: return rn + sh;
            4'd12: return rn | sh;
            4'd13: return sh;
            4'd14: return rn & ~sh;
            4'd15: return ~sh;
            default: return 32'd0;
        endcase
    endfunction

    // Flags from wide signed/unsigned arithmetic rather than bit tricks.
    function automatic logic [3:0] flags_ref(logic [3:0] code, logic [31:0] rn, logic [31:0] sh,
                                             logic [3:0] cpsr);
        logic [31:0] r;
        longint a, b, sd;
        bit c, v;
        r = alu_ref(code, rn, sh);
        a = longint'($signed(rn));
        b = longint'($signed(sh));
        c = cpsr[1];
        v = cpsr[3];
        case (code)
            4'd4, 4'd11: begin
                c = (longint'(rn) + longint'(sh)) > 64'sd4294967295;
                sd = a + b; v = (sd > MAXS) || (sd < MINS);
            end
            4'd2, 4'd10: begin
                c = rn >= sh;
                sd = a - b; v = (sd > MAXS) || (sd < MINS);
            end
            4'd3: begin
                c = sh >= rn;
                sd = b - a; v = (sd > MAXS) || (sd < MINS);
            end
            default: ;
        endcase
        return {v, r[31], c, (r == 32'd0)};
    endfunction

    // Stand-in alu32: bits [3] and [1] are junk so the arbiter must ignore them.
    always_comb begin
        alu_out   = alu_ref(alu_code, alu_rn, alu_shift);
        alu_flags = {1'b1, alu_out[31], 1'b1, (alu_out == 32'd0)};
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check combinational grant, advance the model, check registered outputs.
    task automatic step();
        bit e0, e1;
        int g;
        logic [31:0] r;
        logic [3:0]  f;
        #1;
        g = -1;
        if (!reset) begin
            e0 = req_valid[0] && (!m_full[0] || rsp_ready[0]);
            e1 = req_valid[1] && (!m_full[1] || rsp_ready[1]);
            if (e0 && e1) g = m_pref;
            else if (e0)  g = 0;
            else if (e1)  g = 1;
        end
        dut_r0 = req_ready[0];
        dut_r1 = req_ready[1];
        chk("req0_ready", 32'(req_ready[0]), 32'(g == 0));
        chk("req1_ready", 32'(req_ready[1]), 32'(g == 1));
        chk("alu_code",  32'(alu_code), (g < 0) ? 32'd0 : 32'(req_code[g]));
        chk("alu_rn",    alu_rn,        (g < 0) ? 32'd0 : req_rn[g]);
        chk("alu_shift", alu_shift,     (g < 0) ? 32'd0 : req_shift[g]);
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                m_full[p] = 0; m_out[p] = 0; m_flags[p] = 0;
            end
            m_we = 0; m_wdata = 0; m_pref = 0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (m_full[p] && rsp_ready[p]) m_full[p] = 0;
            m_we = 0;
            if (g >= 0) begin
                r = alu_ref(req_code[g], req_rn[g], req_shift[g]);
                f = flags_ref(req_code[g], req_rn[g], req_shift[g], cpsr_in);
                m_full[g] = 1; m_out[g] = r; m_flags[g] = f;
                m_we = req_s[g];
                if (req_s[g]) m_wdata = f;
                m_pref = 1 - g;
            end
        end
        last_g = g;
        @(posedge clk);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rsp%0d_valid", p), 32'(rsp_valid[p]), 32'(m_full[p]));
            chk($sformatf("rsp%0d_out", p),   rsp_out[p],        m_out[p]);
            chk($sformatf("rsp%0d_flags", p), 32'(rsp_flags[p]), 32'(m_flags[p]));
        end
        chk("cpsr_we",    32'(cpsr_we),    32'(m_we));
        chk("cpsr_wdata", 32'(cpsr_wdata), 32'(m_wdata));
    endtask

    task automatic set_req(int p, bit v, logic [3:0] code, logic [31:0] rn, logic [31:0] sh, bit s);
        req_valid[p] = v; req_code[p] = code; req_rn[p] = rn; req_shift[p] = sh; req_s[p] = s;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 7));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        cpsr_in = 4'd0;
        for (int p = 0; p < 2; p++) begin
            set_req(p, 0, 4'd0, 32'd0, 32'd0, 0);
            rsp_ready[p] = 1'b1;
        end
        step(); step();
        chk("reset_rsp0_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset_cpsr_we",    32'(cpsr_we),      32'd0);
        reset = 1'b0;

        // ADD overflow into sign bit
        set_req(0, 1, 4'd4, 32'h7FFF_FFFF, 32'd1, 1);
        step();
        chk("t1_out",   rsp_out[0],          32'h8000_0000);
        chk("t1_flags", 32'(rsp_flags[0]),   32'hC);
        chk("t1_we",    32'(cpsr_we),        32'd1);
        set_req(0, 0, 4'd0, 32'd0, 32'd0, 0);
        step();
        chk("t1_we_one_cycle", 32'(cpsr_we), 32'd0);

        // SUB equal operands, then AND preserving C/V from cpsr_in
        set_req(0, 1, 4'd2, 32'd5, 32'd5, 1);
        step();
        chk("t4_sub_out",   rsp_out[0],        32'd0);
        chk("t4_sub_flags", 32'(rsp_flags[0]), 32'h3);
        cpsr_in = 4'b0010;
        set_req(0, 1, 4'd0, 32'hF, 32'd0, 1);
        step();
        chk("t4_and_flags", 32'(rsp_flags[0]), 32'h3);
        chk("t4_and_wdata", 32'(cpsr_wdata),   32'h3);

        // RSB and CMN wrap
        cpsr_in = 4'd0;
        set_req(0, 1, 4'd3, 32'd3, 32'd1, 0);
        step();
        chk("t5_rsb_out",   rsp_out[0],        32'hFFFF_FFFE);
        chk("t5_rsb_flags", 32'(rsp_flags[0]), 32'h4);
        set_req(0, 1, 4'd11, 32'hFFFF_FFFF, 32'd1, 0);
        step();
        chk("t5_cmn_flags", 32'(rsp_flags[0]), 32'h3);

        // Fill both slots with an S op strobing, then reset mid-flight
        rsp_ready[0] = 0; rsp_ready[1] = 0;
        set_req(0, 1, 4'd4, 32'd1, 32'd2, 1);
        set_req(1, 0, 4'd0, 32'd0, 32'd0, 0);
        step();
        set_req(0, 0, 4'd0, 32'd0, 32'd0, 0);
        set_req(1, 1, 4'd2, 32'd9, 32'd4, 1);
        step();
        chk("t6_pre_full0", 32'(rsp_valid[0]), 32'd1);
        chk("t6_pre_we",    32'(cpsr_we),      32'd1);
        reset = 1'b1;
        step();
        chk("t6_rsp0_valid", 32'(rsp_valid[0]), 32'd0);
        chk("t6_rsp1_valid", 32'(rsp_valid[1]), 32'd0);
        chk("t6_cpsr_we",    32'(cpsr_we),      32'd0);
        reset = 1'b0;

        // Dual requests after reset alternate starting with port 0
        rsp_ready[0] = 1; rsp_ready[1] = 1;
        set_req(0, 1, 4'd4, 32'd10, 32'd20, 0);
        set_req(1, 1, 4'd2, 32'd10, 32'd20, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t2_r0_%0d", k), 32'(dut_r0), 32'((k % 2) == 0));
            chk($sformatf("t2_r1_%0d", k), 32'(dut_r1), 32'((k % 2) == 1));
        end

        // Port 1 blocked by a full slot; draining it grants port 1 the same cycle
        rsp_ready[1] = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t3_r0_%0d", k), 32'(dut_r0), 32'd1);
            chk($sformatf("t3_r1_%0d", k), 32'(dut_r1), 32'd0);
        end
        rsp_ready[1] = 1;
        step();
        chk("t3_refill_r1", 32'(dut_r1), 32'd1);

        // Randomized traffic; a request is held unchanged until it is accepted
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(req_valid[p] && last_g != p))
                    set_req(p, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                            pick(), pick(), 1'($urandom_range(0, 1)));
                rsp_ready[p] = $urandom_range(0, 3) != 0;
            end
            cpsr_in = 4'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
